// File: rtl/cpu_trace_monitor.sv
// cpu_trace_monitor: retire monitor for the CPU cores.
// Counts retired instructions per opcode class, detects a run of halt
// markers and exposes the counters through a registered read port.
module cpu_trace_monitor #(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned CNT_WIDTH   = 32,
  parameter logic [31:0] HALT_INSN   = 32'h00000000,
  parameter int unsigned HALT_REPEAT = 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_retire_valid,
  input  logic [31:0]          i_instruction,
  input  logic [XLEN-1:0]      i_pc,
  input  logic                 i_branch_taken,
  input  logic                 i_clear,
  input  logic                 i_freeze,
  input  logic [2:0]           i_rd_sel,
  output logic [CNT_WIDTH-1:0] o_rd_data,
  output logic                 o_halted,
  output logic [XLEN-1:0]      o_halt_pc,
  output logic [XLEN-1:0]      o_last_pc
);

  // Counter slots, matching the encoding of i_rd_sel.
  localparam int unsigned SEL_CYCLES  = 0;
  localparam int unsigned SEL_RETIRED = 1;
  localparam int unsigned SEL_RTYPE   = 2;
  localparam int unsigned SEL_LOAD    = 3;
  localparam int unsigned SEL_STORE   = 4;
  localparam int unsigned SEL_BRANCH  = 5;
  localparam int unsigned SEL_TAKEN   = 6;
  localparam int unsigned SEL_ITYPE   = 7;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;

  // Repeat target narrowed to the width of the repeat counter (1..15).
  localparam logic [3:0] HALT_REP_C = 4'(HALT_REPEAT);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PEND   = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t                 r_state;
  logic [3:0]             r_rep_cnt;
  logic [XLEN-1:0]        r_halt_pc;
  logic [XLEN-1:0]        r_last_pc;
  logic [CNT_WIDTH-1:0]   r_rd_data;
  logic [CNT_WIDTH-1:0]   r_cnt [8];

  logic                   w_is_halt;
  logic                   w_count_en;
  logic [6:0]             w_opcode;
  logic [7:0]             w_inc;
  logic [3:0]             w_rep_next;

  // Saturating increment: a counter at all-ones stays there.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (v == {CNT_WIDTH{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  endfunction

  // Decode the retiring instruction and decide which counters step this cycle.
  always_comb begin
    w_opcode   = i_instruction[6:0];
    w_is_halt  = (i_instruction == HALT_INSN);
    w_rep_next = r_rep_cnt + 4'd1;
    w_count_en = (r_state != ST_HALTED) && !i_freeze && !i_clear;
    w_inc      = 8'b0000_0000;
    if (w_count_en) begin
      w_inc[SEL_CYCLES] = 1'b1;
      if (i_retire_valid) begin
        w_inc[SEL_RETIRED] = 1'b1;
        if (!w_is_halt) begin
          case (w_opcode)
            OP_RTYPE:  w_inc[SEL_RTYPE] = 1'b1;
            OP_LOAD:   w_inc[SEL_LOAD]  = 1'b1;
            OP_STORE:  w_inc[SEL_STORE] = 1'b1;
            OP_BRANCH: begin
              w_inc[SEL_BRANCH] = 1'b1;
              w_inc[SEL_TAKEN]  = i_branch_taken;
            end
            OP_ITYPE:  w_inc[SEL_ITYPE] = 1'b1;
            default:   w_inc[SEL_RETIRED] = 1'b1;
          endcase
        end else begin
          w_inc[SEL_RETIRED] = 1'b1;
        end
      end else begin
        w_inc[SEL_RETIRED] = 1'b0;
      end
    end else begin
      w_inc = 8'b0000_0000;
    end
  end

  // Halt-detection FSM: RUN -> PEND -> HALTED, sticky until reset or clear.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= ST_RUN;
      r_rep_cnt <= 4'd0;
      r_halt_pc <= {XLEN{1'b0}};
    end else if (i_clear) begin
      r_state   <= ST_RUN;
      r_rep_cnt <= 4'd0;
      r_halt_pc <= {XLEN{1'b0}};
    end else begin
      case (r_state)
        ST_RUN: begin
          if (i_retire_valid && w_is_halt) begin
            if (HALT_REP_C == 4'd1) begin
              r_state   <= ST_HALTED;
              r_halt_pc <= i_pc;
            end else begin
              r_state   <= ST_PEND;
              r_rep_cnt <= 4'd1;
            end
          end
        end
        ST_PEND: begin
          // Idle cycles leave the repeat count untouched.
          if (i_retire_valid) begin
            if (!w_is_halt) begin
              r_state   <= ST_RUN;
              r_rep_cnt <= 4'd0;
            end else if (w_rep_next == HALT_REP_C) begin
              r_state   <= ST_HALTED;
              r_rep_cnt <= w_rep_next;
              r_halt_pc <= i_pc;
            end else begin
              r_rep_cnt <= w_rep_next;
            end
          end
        end
        ST_HALTED: begin
          r_state <= ST_HALTED;
        end
        default: begin
          r_state   <= ST_RUN;
          r_rep_cnt <= 4'd0;
        end
      endcase
    end
  end

  // Event counters: cleared by clear, stepped by the increment vector.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < 8; i++) begin
        r_cnt[i] <= {CNT_WIDTH{1'b0}};
      end
    end else if (i_clear) begin
      for (int i = 0; i < 8; i++) begin
        r_cnt[i] <= {CNT_WIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (w_inc[i]) begin
          r_cnt[i] <= sat_inc(r_cnt[i]);
        end
      end
    end
  end

  // Track the PC of the latest retire, independent of state, freeze and clear.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_last_pc <= {XLEN{1'b0}};
    end else if (i_retire_valid) begin
      r_last_pc <= i_pc;
    end
  end

  // Read port: register the selected counter as it stood before this edge.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_rd_data <= {CNT_WIDTH{1'b0}};
    end else begin
      r_rd_data <= r_cnt[i_rd_sel];
    end
  end

  assign o_rd_data = r_rd_data;
  assign o_halted  = (r_state == ST_HALTED);
  assign o_halt_pc = r_halt_pc;
  assign o_last_pc = r_last_pc;

endmodule

// File: doc/cpu_trace_monitor.md
Name: cpu_trace_monitor

Overview:
- Synthesizable retire monitor for the sequential and future pipelined CPU cores.
- Watches each retired instruction and keeps per-class event counters.
- Detects the halt condition: a programmable number of consecutive all-zero instructions.
- Exposes counters through a registered read port, replacing ad-hoc testbench halt loops and prints with a reusable, parametrised block.

Parameters:
- XLEN, 64, width of PC and of pc/halt_pc outputs.
- CNT_WIDTH, 32, width of every event counter. Counters saturate at all-ones.
- HALT_INSN, 32'h00000000, instruction encoding treated as halt marker.
- HALT_REPEAT, 1, consecutive retired halt markers required to enter HALTED (1..15).

Ports:
- clk  input  1  core clock. All state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- retire_valid  input  1  an instruction retires this cycle.
- instruction  input  32  retiring instruction word.
- pc  input  XLEN  address of retiring instruction.
- branch_taken  input  1  retiring branch was taken (ignored unless opcode 1100011).
- clear  input  1  synchronous clear of all counters and halt state.
- freeze  input  1  hold all counters (cycle counter included). Halt detection continues.
- rd_sel  input  3  counter select: 0 cycles, 1 retired, 2 R-type, 3 loads, 4 stores, 5 branches, 6 taken branches, 7 I-type ALU.
- rd_data  output  CNT_WIDTH  selected counter, registered, 1-cycle latency.
- halted  output  1  monitor in HALTED state.
- halt_pc  output  XLEN  PC of the halt marker that completed the halt sequence.
- last_pc  output  XLEN  PC of most recent retired instruction.

Behaviour:
- Reset (reset=0, async):
  - all counters = 0, rd_data = 0, halted = 0, halt_pc = 0, last_pc = 0.
  - FSM = RUN, repeat count = 0.
- Opcode classes (instruction[6:0]):
  - 0110011 R-type
  - 0000011 load
  - 0100011 store
  - 1100011 branch
  - 0010011 I-type ALU
  - other opcodes count only toward retired.
- FSM states: RUN, PEND, HALTED.
  - RUN: retire_valid with instruction==HALT_INSN:
    - if HALT_REPEAT==1, go to HALTED and latch halt_pc=pc.
    - else go to PEND with repeat count=1.
  - PEND: another consecutive halt marker increments repeat count.
    - When the count reaches HALT_REPEAT, go to HALTED and latch halt_pc.
    - Any retired non-halt instruction returns to RUN with count=0.
    - Cycles without retire_valid neither advance nor reset the count.
  - HALTED: sticky. Leaves only via reset or clear.
- Counting rules:
  - Counters update only when FSM != HALTED and freeze=0.
  - cycle_count increments every such cycle.
  - With retire_valid=1: retired +1, matching class counter +1, taken +1 if branch and branch_taken.
  - Halt markers count as retired but in no class. The marker that completes the halt is counted; the cycle it retires is counted.
  - last_pc updates on every retire_valid, regardless of state or freeze.
- Saturation: a counter at 2^CNT_WIDTH-1 stays there. There is no wrap.
- clear:
  - Next edge: counters=0, FSM=RUN, halted=0, halt_pc=0, repeat count=0. last_pc is unchanged.
  - clear has priority over a same-cycle retire: that retire is not counted and cannot start a halt sequence.
  - clear with freeze=1 still clears.
- Read port: rd_data at edge N+1 reflects the rd_sel and counter value sampled at edge N, i.e. pre-update.
- halted asserts on the edge that retires the final halt marker. It is combinationally derived from the FSM state register.

Test Plan:
- Reset sequence:
  - Apply reset=0 for 2 cycles, release, then retire addi (00000513), lw (00052583), lw (00852603), addi (00850513), lw (00052683), then 00000000 at pc=0x14 with HALT_REPEAT=1.
  - Required: retired=6, I-type=2, loads=3, halted=1 on that edge, halt_pc=0x14.
  - After halt, retire_valid stays 1 for 5 cycles: all counters frozen.
- Branch and taken:
  - Retire 4 beq (opcode 1100011) with branch_taken=1,0,1,1.
  - Required: branches=4, taken=3. Reading rd_sel=6 gives 3 one cycle after the select.
- HALT_REPEAT=3:
  - Halt, halt, add (00B50533), halt, halt, halt at pcs 0,4,8,C,10,14.
  - Required: no halt until the last marker, halted=1, halt_pc=0x14, R-type=1.
- Saturation:
  - CNT_WIDTH=4, retire 20 addi.
  - Required: retired=15, I-type=15, cycle counter=15, no wrap.
- Freeze and clear:
  - Freeze for 3 cycles during retires: counters unchanged, last_pc tracks.
  - Then clear together with a retire: all counters 0, halted=0, that retire not counted.
- Async reset mid-operation:
  - Assert reset=0 between clock edges while in PEND.
  - Required: outputs zero immediately without a clock edge. After release, FSM is in RUN and a single marker does not halt when HALT_REPEAT=2.
